// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and types, used by FFT_top and the peak detector.
package fft_pkg;
  localparam int N_POINTS = 1024;
  localparam int LOG2_N   = $clog2(N_POINTS);
  localparam int DATA_W   = 16;
  localparam int MAG_W    = 2 * DATA_W;

  typedef logic        [LOG2_N-1:0] bin_t;
  typedef logic        [MAG_W-1:0]  mag_t;
  typedef logic signed [DATA_W-1:0] sample_t;
endpackage

// File: rtl/fft_mag_sq.sv
// Registered |X|^2 stage: re*re + im*im with bin tags carried alongside, one cycle latency.
module fft_mag_sq
  import fft_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    valid_i,
  input  sample_t re_i,
  input  sample_t im_i,
  input  bin_t    bin_i,
  input  logic    first_i,
  input  logic    last_i,
  output logic    valid_o,
  output mag_t    mag_o,
  output bin_t    bin_o,
  output logic    first_o,
  output logic    last_o
);
  logic signed [MAG_W-1:0] re_x_s, im_x_s, re_sq_s, im_sq_s;
  mag_t mag_d;
  logic valid_q, first_q, last_q;
  mag_t mag_q;
  bin_t bin_q;

  // Squares are non-negative and at most 2^30, so the sum always fits MAG_W unsigned bits.
  assign re_x_s  = MAG_W'(re_i);
  assign im_x_s  = MAG_W'(im_i);
  assign re_sq_s = re_x_s * re_x_s;
  assign im_sq_s = im_x_s * im_x_s;
  assign mag_d   = mag_t'(re_sq_s) + mag_t'(im_sq_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      mag_q   <= '0;
      bin_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        mag_q   <= mag_d;
        bin_q   <= bin_i;
        first_q <= first_i;
        last_q  <= last_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign mag_o   = mag_q;
  assign bin_o   = bin_q;
  assign first_o = first_q;
  assign last_o  = last_q;
endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame strongest-bin detector on the streamed FFT output (ties keep the lowest bin).
// Define PEAK_SKIP_DC_EN to exclude bin 0 from the search.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int SEARCH_BINS = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] Xb_re,
  input  logic signed [DATA_W-1:0] Xb_im,
  output logic                     peak_valid,
  output logic        [LOG2_N-1:0] peak_bin,
  output logic        [MAG_W-1:0]  peak_mag
);
  bin_t    bin_cnt_q;
  logic    s1_valid_q, s1_first_q, s1_last_q;
  sample_t s1_re_q, s1_im_q;
  bin_t    s1_bin_q;

  logic    s2_valid_s, s2_first_s, s2_last_s;
  mag_t    s2_mag_s;
  bin_t    s2_bin_s;

  logic    cand_s, in_range_s;
  mag_t    max_q, max_d;
  bin_t    idx_q, idx_d;
  logic    have_q, have_d, done_q;

  logic    peak_valid_q;
  bin_t    peak_bin_q;
  mag_t    peak_mag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_bin_q   <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= enable;
      if (enable) begin
        bin_cnt_q  <= bin_cnt_q + bin_t'(1);
        s1_re_q    <= Xb_re;
        s1_im_q    <= Xb_im;
        s1_bin_q   <= bin_cnt_q;
        s1_first_q <= (bin_cnt_q == bin_t'(0));
        s1_last_q  <= (bin_cnt_q == bin_t'(N_POINTS - 1));
      end
    end
  end

  fft_mag_sq u_mag_sq (
    .clk     (clk),
    .rst     (rst),
    .valid_i (s1_valid_q),
    .re_i    (s1_re_q),
    .im_i    (s1_im_q),
    .bin_i   (s1_bin_q),
    .first_i (s1_first_q),
    .last_i  (s1_last_q),
    .valid_o (s2_valid_s),
    .mag_o   (s2_mag_s),
    .bin_o   (s2_bin_s),
    .first_o (s2_first_s),
    .last_o  (s2_last_s)
  );

  assign in_range_s = ({1'b0, s2_bin_s} < (LOG2_N + 1)'(SEARCH_BINS));
`ifdef PEAK_SKIP_DC_EN
  assign cand_s = in_range_s && (s2_bin_s != bin_t'(0));
`else
  assign cand_s = in_range_s;
`endif

  // have_q marks that the frame has seen a candidate, so the first one loads regardless of mag.
  always_comb begin
    max_d  = max_q;
    idx_d  = idx_q;
    have_d = have_q;
    if (s2_valid_s) begin
      if (s2_first_s) begin
        have_d = cand_s;
        max_d  = cand_s ? s2_mag_s : '0;
        idx_d  = s2_bin_s;
      end else if (cand_s && (!have_q || (s2_mag_s > max_q))) begin
        have_d = 1'b1;
        max_d  = s2_mag_s;
        idx_d  = s2_bin_s;
      end else begin
        have_d = have_q;
      end
    end else begin
      have_d = have_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q        <= '0;
      idx_q        <= '0;
      have_q       <= 1'b0;
      done_q       <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
    end else begin
      max_q        <= max_d;
      idx_q        <= idx_d;
      have_q       <= have_d;
      done_q       <= s2_valid_s && s2_last_s;
      peak_valid_q <= done_q;
      if (done_q) begin
        peak_bin_q <= idx_q;
        peak_mag_q <= max_q;
      end
    end
  end

  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
endmodule
